// File: rtl/sgpio_tx.sv
// SGPIO initiator: serializes per-drive ACT/LOC/FLT LED requests onto SCLK/SLOAD/SDOUT frames.
// Latency: first SCLK rise 1 SYSCLK after ENABLE seen in IDLE; frame = (1+3*HDD_NUM+GAP_CYCLES)*2*CLK_DIV cycles.
// Backpressure: none; the target samples on SCLK falling edges and the frame rate is fixed by CLK_DIV.
//
// Ports:
//   SYSCLK, RESET (sync, active-high), ENABLE (level, run frames continuously)
//   ACT_LED/LOC_LED/FLT_LED [HDD_NUM-1:0] : per-drive requests, snapshotted at frame start
//   SCLK/SLOAD/SDOUT : SGPIO serial interface, SCLK idles low
//   BUSY : high whenever the FSM is outside IDLE
//   FRAME_DONE : one-cycle pulse on the rising-edge slot after the last data bit
module sgpio_tx #(
  parameter int HDD_NUM    = 8,
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 0
) (
  input  logic               SYSCLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic [HDD_NUM-1:0] ACT_LED,
  input  logic [HDD_NUM-1:0] LOC_LED,
  input  logic [HDD_NUM-1:0] FLT_LED,
  output logic               SCLK,
  output logic               SLOAD,
  output logic               SDOUT,
  output logic               BUSY,
  output logic               FRAME_DONE
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]       DRV_LAST = 7'(HDD_NUM - 1);
  // Only meaningful when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
  localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DATA,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               sclk_q, sclk_d;
  logic               sload_q, sload_d;
  logic               sdout_q, sdout_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [6:0]         drive_q, drive_d;
  logic [1:0]         sub_q, sub_d;
  logic [7:0]         gap_q, gap_d;
  logic [HDD_NUM-1:0] act_snap_q, act_snap_d;
  logic [HDD_NUM-1:0] loc_snap_q, loc_snap_d;
  logic [HDD_NUM-1:0] flt_snap_q, flt_snap_d;

  logic       tick;
  logic       rise;
  logic       start_frame;
  logic       go_idle;
  logic [6:0] nxt_drive;
  logic [1:0] nxt_sub;
  logic       nxt_bit;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    sclk_d       = sclk_q;
    sload_d      = sload_q;
    sdout_d      = sdout_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    drive_d      = drive_q;
    sub_d        = sub_q;
    gap_d        = gap_q;
    act_snap_d   = act_snap_q;
    loc_snap_d   = loc_snap_q;
    flt_snap_d   = flt_snap_q;
    start_frame  = 1'b0;
    go_idle      = 1'b0;

    // Rising-edge slot: the SYSCLK edge on which SCLK goes 0->1. SLOAD/SDOUT
    // only change here so they are stable across the target's falling edge.
    tick = (div_q == DIV_LAST);
    rise = tick & ~sclk_q;

    // Bit index following the one currently on SDOUT.
    if (sub_q == 2'd2) begin
      nxt_sub   = 2'd0;
      nxt_drive = drive_q + 7'd1;
    end else begin
      nxt_sub   = sub_q + 2'd1;
      nxt_drive = drive_q;
    end

    nxt_bit = 1'b0;
    for (int i = 0; i < HDD_NUM; i++) begin
      if (nxt_drive == 7'(i)) begin
        case (nxt_sub)
          2'd0:    nxt_bit = act_snap_q[i];
          2'd1:    nxt_bit = loc_snap_q[i];
          default: nxt_bit = flt_snap_q[i];
        endcase
      end
    end

    case (state_q)
      S_IDLE: begin
        div_d  = '0;
        sclk_d = 1'b0;
        if (ENABLE) start_frame = 1'b1;
      end
      default: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) sclk_d = ~sclk_q;
        if (rise) begin
          case (state_q)
            S_LOAD: begin
              state_d = S_DATA;
              sload_d = 1'b0;
              sdout_d = act_snap_q[0];
              drive_d = 7'd0;
              sub_d   = 2'd0;
            end
            S_DATA: begin
              if (drive_q == DRV_LAST && sub_q == 2'd2) begin
                frame_done_d = 1'b1;
                if (GAP_CYCLES > 0) begin
                  state_d = S_GAP;
                  gap_d   = 8'd0;
                  sload_d = 1'b0;
                  sdout_d = 1'b0;
                end else if (ENABLE) begin
                  start_frame = 1'b1;
                end else begin
                  go_idle = 1'b1;
                end
              end else begin
                drive_d = nxt_drive;
                sub_d   = nxt_sub;
                sdout_d = nxt_bit;
              end
            end
            S_GAP: begin
              if (gap_q == GAP_LAST) begin
                if (ENABLE) start_frame = 1'b1;
                else        go_idle     = 1'b1;
              end else begin
                gap_d = gap_q + 8'd1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    if (start_frame) begin
      state_d    = S_LOAD;
      act_snap_d = ACT_LED;
      loc_snap_d = LOC_LED;
      flt_snap_d = FLT_LED;
      div_d      = '0;
      sclk_d     = 1'b1;
      sload_d    = 1'b1;
      sdout_d    = 1'b0;
      busy_d     = 1'b1;
      drive_d    = 7'd0;
      sub_d      = 2'd0;
      gap_d      = 8'd0;
    end

    // Leaving on a rising-edge slot: suppress the SCLK rise so it parks low.
    if (go_idle) begin
      state_d = S_IDLE;
      div_d   = '0;
      sclk_d  = 1'b0;
      sload_d = 1'b0;
      sdout_d = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      sclk_q       <= 1'b0;
      sload_q      <= 1'b0;
      sdout_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      drive_q      <= 7'd0;
      sub_q        <= 2'd0;
      gap_q        <= 8'd0;
      act_snap_q   <= '0;
      loc_snap_q   <= '0;
      flt_snap_q   <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      sclk_q       <= sclk_d;
      sload_q      <= sload_d;
      sdout_q      <= sdout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      drive_q      <= drive_d;
      sub_q        <= sub_d;
      gap_q        <= gap_d;
      act_snap_q   <= act_snap_d;
      loc_snap_q   <= loc_snap_d;
      flt_snap_q   <= flt_snap_d;
    end
  end

  assign SCLK       = sclk_q;
  assign SLOAD      = sload_q;
  assign SDOUT      = sdout_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: doc/sgpio_tx.md
Name: sgpio_tx

Overview:
SGPIO initiator for the status CPLD. It serializes per-drive activity, locate and fault LED requests onto SCLK/SLOAD/SDOUT toward a downstream backplane target. Frames repeat continuously while ENABLE is high. Each frame has one SLOAD marker bit followed by three bits per drive, in the order ACT, LOC, FLT, starting with drive 0. The block sits beside the SGPIO receive path and shares the SYSCLK domain.

Parameters:
HDD_NUM, 8, number of drives per frame (1..64)
CLK_DIV, 50, SYSCLK cycles per SCLK half-period (>=1)
GAP_CYCLES, 0, idle SCLK periods between frames (SLOAD=0, SDOUT=0), 0..255

Ports:
SYSCLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
ENABLE  in  1  level; 1 = run frames continuously
ACT_LED  in  HDD_NUM  activity request per drive, 1 = on
LOC_LED  in  HDD_NUM  locate request per drive, 1 = on
FLT_LED  in  HDD_NUM  fault request per drive, 1 = on
SCLK  out  1  SGPIO clock, idle low
SLOAD  out  1  frame marker
SDOUT  out  1  serial data
BUSY  out  1  1 while any state other than IDLE is active
FRAME_DONE  out  1  one-SYSCLK pulse at the end of each frame's last data bit

Behaviour:
- Interface: one clock, SYSCLK. RESET is synchronous and active-high.
- Reset values: SCLK=0, SLOAD=0, SDOUT=0, BUSY=0, FRAME_DONE=0, state IDLE, all counters 0, snapshots 0. Reset applied mid-frame returns these values at the next SYSCLK edge; no partial frame completes.
- Divider DIV_CNT counts 0..CLK_DIV-1 and is held at 0 in IDLE. Each terminal count toggles SCLK, giving an SCLK period of 2*CLK_DIV SYSCLK cycles.
- SLOAD and SDOUT change only on the SYSCLK edge where SCLK goes 0->1. They stay stable through the following 1->0 edge, which is the target's sampling edge.
- States:
  - IDLE: SCLK held low. If ENABLE=1, on the next edge: latch ACT/LOC/FLT snapshots, SCLK<=1, SLOAD<=1, SDOUT<=0, go to LOAD. Latency from ENABLE rising to the first SCLK rise is 1 SYSCLK.
  - LOAD: one SCLK period. At the next rising edge: SLOAD<=0, SDOUT<=ACT_snap[0], drive=0, sub=0, go to DATA.
  - DATA: one SCLK period per bit. sub 0/1/2 selects ACT/LOC/FLT of the current drive. At each rising edge, sub increments; on sub=2 it wraps to 0 and drive increments. The last bit is drive=HDD_NUM-1, sub=2. At the rising-edge slot after the last bit, FRAME_DONE pulses for 1 cycle, then:
    - if GAP_CYCLES>0: go to GAP, with SLOAD=0, SDOUT=0, SCLK toggling.
    - else if ENABLE=1: start a new frame directly, with a new snapshot and SLOAD<=1 (back-to-back frames).
    - else: go to IDLE with SCLK left low, SLOAD=0, SDOUT=0.
  - GAP: lasts GAP_CYCLES full SCLK periods. At the final rising-edge slot: if ENABLE=1, start a new frame as in IDLE (snapshot, SLOAD<=1, LOAD); else go to IDLE with SCLK low.
- Snapshot inputs are sampled only at frame start. LED input changes mid-frame affect the next frame only.
- ENABLE falling mid-frame: the frame completes, including any GAP, then the block goes to IDLE. ENABLE is only examined at the IDLE and frame-boundary decision points.
- Counter width: drive counter is 7 bits, compared against HDD_NUM-1, and never exceeds it.
- Frame length: (1 + 3*HDD_NUM + GAP_CYCLES) * 2*CLK_DIV SYSCLK cycles.
- BUSY is registered and is 1 from the edge that leaves IDLE until the edge that re-enters IDLE.

Test Plan:
- Reset check: hold RESET for 3 cycles with ENABLE=1 -> all outputs 0. Release RESET -> first SCLK rise 1 cycle later with SLOAD=1.
- Bit order, with HDD_NUM=4, CLK_DIV=2, GAP=0, ACT=4'b0101, LOC=4'b0000, FLT=4'b1000 -> SDOUT sampled on SCLK falls after the SLOAD bit reads 1,0,0, 0,0,0, 1,0,0, 0,0,1. FRAME_DONE pulses 52 cycles after the frame starts.
- Snapshot: change ACT to 4'b1111 mid-frame -> the current frame keeps the old bits and the next frame carries 1s in the ACT slots.
- Gap and stop, with GAP_CYCLES=2 -> two SCLK periods with SLOAD=0 between frames. Drop ENABLE mid-frame -> the frame and gap finish, then SCLK stays low and BUSY=0.
- Reset mid-frame: assert RESET at drive 2 -> next edge SCLK=SLOAD=SDOUT=BUSY=0. After release with ENABLE=1 -> a fresh frame starts at the SLOAD bit.
- CLK_DIV=1 -> SCLK toggles every cycle, and a 4-drive frame is 26 cycles with correct data.
